rotate_seq: RTL and testbench

Sequential multi-step rotator that wraps the existing combinational rotateN stage. It holds an N-bit working register that drives rotateN's input and captures rotateN's output on each clock. After a START, the register rotates by a programmable amount, one position per clock, in the requested direction. It reports progress with a BUSY/DONE handshake and feeds downstream datapath logic.

---
 rtl/rotate_seq.sv | 120 ++++++++++++
 tb/tb_rotate_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_seq.sv
// rtl/rotate_seq.sv - multi-step sequential rotator around a one-position rotateN stage

// Combinational single-position rotate: dir=1 rotates right (LSB wraps to MSB),
// dir=0 rotates left (MSB wraps to LSB).
module rotateN #(
  parameter int N = 8
) (
  input  logic [N-1:0] din,
  input  logic         dir,
  output logic [N-1:0] dout
);

  // One-position rotate, direction selected by dir
  always_comb begin
    dout = din;
    if (dir) begin
      dout = {din[0], din[N-1:1]};
    end else begin
      dout = {din[N-2:0], din[N-1]};
    end
  end

endmodule

// Sequencer: loads a working register, then rotates it one position per clock
// for AMT clocks in the direction latched at START. BUSY covers the rotate
// steps; DONE is a single-cycle pulse in the FIN state that follows.
module rotate_seq #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         LOAD,
  input  logic [N-1:0] DIN,
  input  logic         START,
  input  logic         DIR,
  input  logic [W-1:0] AMT,
  output logic [N-1:0] DOUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ROTATE = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] work;
  logic [N-1:0] rot_out;
  logic [W-1:0] count;
  logic         dir_q;
  logic         busy_q;
  logic         done_q;

  // The stage always sees the working register and the direction captured at
  // START, so DIR changes while rotating cannot affect the result.
  rotateN #(.N(N)) u_rot (
    .din  (work),
    .dir  (dir_q),
    .dout (rot_out)
  );

  // Control state, working register and registered BUSY/DONE
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      work   <= '0;
      count  <= '0;
      dir_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          if (LOAD) begin
            // LOAD wins over a simultaneous START; no operation begins
            work <= DIN;
          end else if (START) begin
            dir_q <= DIR;
            if (AMT != '0) begin
              count  <= AMT;
              busy_q <= 1'b1;
              state  <= ROTATE;
            end else begin
              // Zero-step rotate still reports completion
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        ROTATE: begin
          work  <= rot_out;
          count <= count - 1'b1;
          if (count == W'(1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign DOUT = work;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_rotate_seq.sv
// tb/tb_rotate_seq.sv - self-checking bench for rotate_seq with a reference rotate model

module tb_rotate_seq;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         CLK;
  logic         RESET;
  logic         LOAD;
  logic [N-1:0] DIN;
  logic         START;
  logic         DIR;
  logic [W-1:0] AMT;
  logic [N-1:0] DOUT;
  logic         BUSY;
  logic         DONE;

  int checks;
  int failures;
  logic [N-1:0] model;

  rotate_seq #(.N(N)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .LOAD  (LOAD),
    .DIN   (DIN),
    .START (START),
    .DIR   (DIR),
    .AMT   (AMT),
    .DOUT  (DOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: rotate x by k positions in one shot using shifts
  function automatic logic [N-1:0] rot(input logic [N-1:0] x, input bit right, input int k);
    int kk;
    logic [2*N-1:0] dbl;
    kk = k % N;
    dbl = {x, x};
    if (right) return dbl[kk +: N];
    else       return dbl[(N - kk) % N +: N];
  endfunction

  function automatic int popcnt(input logic [N-1:0] x);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(x[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic perturb();
    LOAD  = 1'($urandom);
    START = 1'($urandom);
    DIR   = 1'($urandom);
    AMT   = W'($urandom);
    DIN   = N'($urandom);
  endtask

  task automatic do_load(input logic [N-1:0] v, input string tag);
    LOAD = 1'b1; START = 1'b0; DIN = v;
    step();
    LOAD = 1'b0;
    model = v;
    chk({tag, "_dout"}, 32'(DOUT), 32'(model));
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
  endtask

  task automatic run_op(input bit d, input int amt, input bit noisy, input string tag);
    logic [N-1:0] base;
    base = model;
    LOAD = 1'b0; START = 1'b1; DIR = d; AMT = W'(amt);
    step();
    START = 1'b0;
    chk({tag, "_e0_busy"}, 32'(BUSY), 32'(amt != 0));
    chk({tag, "_e0_done"}, 32'(DONE), 32'(amt == 0));
    chk({tag, "_e0_dout"}, 32'(DOUT), 32'(base));
    for (int i = 1; i <= amt; i++) begin
      if (noisy) perturb();
      step();
      chk({tag, "_step_dout"}, 32'(DOUT), 32'(rot(base, d, i)));
      chk({tag, "_step_busy"}, 32'(BUSY), 32'(i < amt));
      chk({tag, "_step_done"}, 32'(DONE), 32'(i == amt));
      chk({tag, "_excl"}, 32'(BUSY & DONE), 32'd0);
    end
    model = rot(base, d, amt);
    if (noisy) perturb();
    step();
    LOAD = 1'b0; START = 1'b0;
    chk({tag, "_fin_done"}, 32'(DONE), 32'd0);
    chk({tag, "_fin_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_fin_dout"}, 32'(DOUT), 32'(model));
    chk({tag, "_popcnt"}, 32'(popcnt(DOUT)), 32'(popcnt(base)));
  endtask

  initial begin
    checks = 0; failures = 0; model = '0;
    RESET = 1'b1; LOAD = 1'b0; DIN = '0; START = 1'b0; DIR = 1'b0; AMT = '0;
    #12;
    chk("rst_dout", 32'(DOUT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RESET = 1'b0;
    step();

    // Asynchronous reset mid-cycle clears immediately
    do_load(8'hFF, "pre_rst");
    #3 RESET = 1'b1;
    #1;
    chk("async_rst_dout", 32'(DOUT), 32'd0);
    chk("async_rst_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    model = '0;
    step();

    // Directed cases from the plan
    do_load(8'b10101100, "ld1");
    run_op(1'b1, 1, 1'b0, "r1");
    chk("r1_const", 32'(DOUT), 32'(8'b01010110));

    do_load(8'b10101100, "ld2");
    LOAD = 1'b0; START = 1'b1; DIR = 1'b0; AMT = 3'd3;
    step();
    START = 1'b0;
    step(); chk("l3_s1", 32'(DOUT), 32'(8'b01011001));
    step(); chk("l3_s2", 32'(DOUT), 32'(8'b10110010));
    step(); chk("l3_s3", 32'(DOUT), 32'(8'b01100101));
    chk("l3_done", 32'(DONE), 32'd1);
    chk("l3_busy", 32'(BUSY), 32'd0);
    step(); chk("l3_done_low", 32'(DONE), 32'd0);
    model = 8'b01100101;

    do_load(8'b10101100, "ld3");
    run_op(1'b1, 7, 1'b1, "r7");
    chk("r7_const", 32'(DOUT), 32'(8'b01011001));

    run_op(1'b0, 0, 1'b0, "a0");
    chk("a0_unchanged", 32'(DOUT), 32'(8'b01011001));

    // LOAD and START together: load only
    LOAD = 1'b1; START = 1'b1; DIN = 8'h3C; DIR = 1'b1; AMT = 3'd2;
    step();
    LOAD = 1'b0; START = 1'b0;
    chk("ldst_dout", 32'(DOUT), 32'h3C);
    chk("ldst_busy", 32'(BUSY), 32'd0);
    chk("ldst_done", 32'(DONE), 32'd0);
    step();
    chk("ldst_busy2", 32'(BUSY), 32'd0);
    chk("ldst_done2", 32'(DONE), 32'd0);
    model = 8'h3C;

    // Reset in the middle of a rotate
    do_load(8'b10101100, "ld4");
    START = 1'b1; DIR = 1'b0; AMT = 3'd5;
    step();
    START = 1'b0;
    step(); step();
    chk("mid_s2", 32'(DOUT), 32'(rot(8'b10101100, 1'b0, 2)));
    #3 RESET = 1'b1;
    #1;
    chk("mid_rst_dout", 32'(DOUT), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_rst_nodone", 32'(DONE), 32'd0);
      chk("mid_rst_nobusy", 32'(BUSY), 32'd0);
    end
    model = '0;
    do_load(8'h81, "ld5");
    run_op(1'b1, 3, 1'b0, "after_rst");

    // Randomized operations, back to back, with noisy inputs while busy
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(3, 0) == 0) do_load(N'($urandom), "rnd_ld");
      run_op(1'($urandom), int'($urandom_range(N - 1, 0)), 1'($urandom), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
